mem_1rw_mask_rmw: RTL and testbench
===================================

Name: mem_1rw_mask_rmw

Overview:
- Parametrised single-port (1RW) memory wrapper with byte/lane write masks, built on sram_1rw_128X64 macros that have no native bit-write support.
- Partial-mask writes are done as an internal read-modify-write (RMW).
- Depth is banked across multiple macros and width is tiled across macro columns.
- Sits where generated 1RW memories need mask_gran support on the arm target.

Parameters:
- DEPTH, 48, number of words; any value ≥1.
- WIDTH, 64, word width; must be a multiple of 64.
- MASK_GRAN, 8, bits per mask lane; must divide WIDTH.
- MACRO_DEPTH, 128, rows per macro; fixed by sram_1rw_128X64.
- ADDR_W, clog2(DEPTH) (min 1), address width.
- Derived: NBANK=ceil(DEPTH/128), NCOL=WIDTH/64, NLANE=WIDTH/MASK_GRAN.

Ports:
- RW0_clk  in  1  sole clock; also drives every macro CLK.
- RW0_reset  in  1  synchronous, active-high reset.
- RW0_addr  in  ADDR_W  word address.
- RW0_en  in  1  request valid.
- RW0_wmode  in  1  1=write, 0=read.
- RW0_wdata  in  WIDTH  write data.
- RW0_wmask  in  NLANE  lane write enables; bit i covers wdata[i*MASK_GRAN +: MASK_GRAN].
- RW0_ready  out  1  request accepted when RW0_en && RW0_ready.
- RW0_rdata  out  WIDTH  read data.
- RW0_rvalid  out  1  one-cycle pulse when RW0_rdata is updated.
- RW0_rmw_count  out  16  saturating count of completed RMW writes.

Behaviour:
- Clock and reset: one clock, RW0_clk. RW0_reset is synchronous and active-high.
- Reset: state=IDLE; RW0_ready=0 in any cycle where reset is sampled high, and 1 from the first cycle after; RW0_rvalid=0; RW0_rdata=0; RW0_rmw_count=0.
- Macro control in reset cycles: all macro CEN=1 whenever RW0_reset=1. An in-flight RMW is aborted and its write never issued.
- Macro tie-offs: EMA=3'd3, EMAW=2'd2, RET1N=1.
- Macro addressing: A = addr % 128, zero-extended to 7 bits. bank = addr / 128.
- Bank/column enables: only the selected bank's NCOL macros get CEN=0. WEN is active-low.
- Out-of-range address (addr ≥ DEPTH): no macro enabled.
  - Out-of-range read: returns RW0_rdata=0 with RW0_rvalid pulse.
  - Out-of-range write: completes silently.
- States: IDLE, MERGE.
- IDLE, read accepted (cycle T):
  - Macro read issued in T.
  - Bank index registered.
  - At T+1: RW0_rdata = Q of the registered bank (0 if out of range), RW0_rvalid=1.
  - RW0_rdata holds until the next read completes.
  - ready stays 1, so back-to-back reads give 1/cycle throughput.
- IDLE, write with wmask all-ones: single macro write in T, WEN=0. ready stays 1. No rvalid.
- IDLE, write with wmask all-zero: no macro access. Completes in T. Not counted.
- IDLE, write with partial wmask:
  - Macro read issued in T.
  - addr, wdata and wmask are captured.
  - Next state MERGE, with ready=0 during MERGE.
- MERGE (T+1):
  - merged = per lane, wmask[i] ? wdata lane : Q lane.
  - Macro write issued to the captured addr.
  - rmw_count increments, saturating at 16'hFFFF.
  - Return to IDLE, ready=1 at T+2.
  - No rvalid; rdata is unchanged by the RMW read.
- Ordering: requests complete in acceptance order. A read following an RMW to the same address returns the merged data.
- RW0_en while ready=0 is not accepted. The requester must hold the request.
- wdata/wmask are ignored for reads. wmode is ignored when en=0.

Test Plan:
1. Reset, then 4 writes with full mask: addr 0..3, data 64'h1111_0000_0000_000{0..3}. Read back addr 0..3 back-to-back → rvalid pulse each cycle T+1, data matches, ready constantly 1.
2. Write addr 5 = 64'h0123_4567_89AB_CDEF with full mask. Then write 64'hFFFF_FFFF_FFFF_FFFF with wmask=8'h0F → ready low exactly 1 cycle. Read addr 5 → 64'h0123_4567_FFFF_FFFF. rmw_count=1.
3. Write with wmask=8'h00 to addr 5 → no macro CEN low, ready stays 1. Read → value unchanged. rmw_count unchanged.
4. Read/write at addr 48 (DEPTH=48): all CEN=1. Read returns 0 with rvalid=1.
5. Config DEPTH=200, WIDTH=128:
   - Write addr 130 (bank 1, A=2) and addr 2 (bank 0) with distinct data.
   - Read both → correct data, no aliasing.
   - Partial mask 16'h00F0 on addr 130 merges only bytes 4-7.
6. Assert RW0_reset during MERGE → no write reaches the macro, and the target word keeps its old value. Next cycle after reset: ready=1, rmw_count=0, rdata=0, rvalid=0.

Source files
------------

// File: rtl/mem_1rw_mask_rmw.sv
// Masked 1RW memory built from sram_1rw_128X64 macros; partial-mask writes become
// a two-cycle read-modify-write, depth is banked by 128 rows and width tiled by 64 bits.

module sram_1rw_128X64 (
    input  logic        CLK,
    input  logic        CEN,
    input  logic        WEN,
    input  logic [6:0]  A,
    input  logic [63:0] D,
    output logic [63:0] Q,
    input  logic [2:0]  EMA,
    input  logic [1:0]  EMAW,
    input  logic        RET1N
);
    logic [63:0] mem [0:127];
    wire unused_tie = ^{EMA, EMAW, RET1N};

    // Q only changes on a read access, as on the real macro
    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!WEN) mem[A] <= D;
            else      Q <= mem[A];
        end
    end
endmodule

module mem_1rw_mask_rmw #(
    parameter int DEPTH       = 48,
    parameter int WIDTH       = 64,
    parameter int MASK_GRAN   = 8,
    parameter int MACRO_DEPTH = 128,
    parameter int ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       RW0_clk,
    input  logic                       RW0_reset,
    input  logic [ADDR_W-1:0]          RW0_addr,
    input  logic                       RW0_en,
    input  logic                       RW0_wmode,
    input  logic [WIDTH-1:0]           RW0_wdata,
    input  logic [WIDTH/MASK_GRAN-1:0] RW0_wmask,
    output logic                       RW0_ready,
    output logic [WIDTH-1:0]           RW0_rdata,
    output logic                       RW0_rvalid,
    output logic [15:0]                RW0_rmw_count
);
    localparam int NBANK  = (DEPTH + MACRO_DEPTH - 1) / MACRO_DEPTH;
    localparam int NCOL   = WIDTH / 64;
    localparam int NLANE  = WIDTH / MASK_GRAN;
    localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] MERGE = 1'b1;

    logic [0:0]              state;
    logic [ADDR_W-1:0]       cap_addr;
    logic [WIDTH-1:0]        cap_wdata;
    logic [NLANE-1:0]        cap_wmask;
    logic [BANK_W-1:0]       rd_bank;
    logic                    rd_inr;
    logic                    rvalid_q;
    logic [WIDTH-1:0]        rdata_q;
    logic [15:0]             rmw_cnt;

    logic                    accept, req_inr, full, none, go_rmw;
    logic                    op_en, op_we;
    logic [ADDR_W-1:0]       op_addr;
    logic [WIDTH-1:0]        op_d, merged, rd_word;
    logic [BANK_W-1:0]       op_bank;
    logic [6:0]              op_row;
    logic [NBANK-1:0][NCOL-1:0] cen;
    logic [NBANK-1:0][WIDTH-1:0] q_all;

    assign RW0_ready = !RW0_reset && (state == IDLE);
    assign accept    = RW0_en && RW0_ready;
    assign req_inr   = 32'(RW0_addr) < 32'(DEPTH);
    assign full      = &RW0_wmask;
    assign none      = ~|RW0_wmask;
    // out-of-range partial writes finish immediately rather than entering MERGE
    assign go_rmw    = accept && RW0_wmode && !full && !none && req_inr;

    always_comb begin
        op_en   = 1'b0;
        op_we   = 1'b0;
        op_addr = RW0_addr;
        op_d    = RW0_wdata;
        if (!RW0_reset) begin
            if (state == MERGE) begin
                op_en   = 1'b1;
                op_we   = 1'b1;
                op_addr = cap_addr;
                op_d    = merged;
            end else if (accept && req_inr) begin
                if (!RW0_wmode)  op_en = 1'b1;
                else if (full) begin
                    op_en = 1'b1;
                    op_we = 1'b1;
                end else if (!none) op_en = 1'b1;
            end
        end
    end

    assign op_bank = BANK_W'(32'(op_addr) / MACRO_DEPTH);
    assign op_row  = 7'(32'(op_addr) % MACRO_DEPTH);
    assign rd_word = rd_inr ? q_all[rd_bank] : '0;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        assign merged[i*MASK_GRAN +: MASK_GRAN] = cap_wmask[i] ? cap_wdata[i*MASK_GRAN +: MASK_GRAN]
                                                               : q_all[rd_bank][i*MASK_GRAN +: MASK_GRAN];
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        for (genvar c = 0; c < NCOL; c++) begin : g_col
            assign cen[b][c] = !(op_en && (op_bank == BANK_W'(b)));
            sram_1rw_128X64 u_mac (
                .CLK   (RW0_clk),
                .CEN   (cen[b][c]),
                .WEN   (!op_we),
                .A     (op_row),
                .D     (op_d[c*64 +: 64]),
                .Q     (q_all[b][c*64 +: 64]),
                .EMA   (3'd3),
                .EMAW  (2'd2),
                .RET1N (1'b1)
            );
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            state    <= IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rmw_cnt  <= '0;
            rd_inr   <= 1'b0;
            rd_bank  <= '0;
        end else begin
            if (rvalid_q) rdata_q <= rd_word;
            rvalid_q <= accept && !RW0_wmode;
            // rd_bank also selects the Q used by the merge cycle
            if (accept) begin
                rd_bank <= op_bank;
                rd_inr  <= req_inr;
            end
            if (go_rmw) begin
                state     <= MERGE;
                cap_addr  <= RW0_addr;
                cap_wdata <= RW0_wdata;
                cap_wmask <= RW0_wmask;
            end else if (state == MERGE) begin
                state <= IDLE;
                if (rmw_cnt != 16'hFFFF) rmw_cnt <= rmw_cnt + 16'd1;
            end
        end
    end

    assign RW0_rdata     = rvalid_q ? rd_word : rdata_q;
    assign RW0_rvalid    = rvalid_q;
    assign RW0_rmw_count = rmw_cnt;
endmodule

// File: tb/tb_mem_1rw_mask_rmw.sv
// Directed bench: a 48x64 instance driven from a vector table plus a 200x128 instance
// exercised by hand-written bank/merge sequences.

module tb_mem_1rw_mask_rmw;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [5:0]   a_addr;
    logic         a_en, a_wmode, a_ready, a_rvalid;
    logic [63:0]  a_wdata, a_rdata;
    logic [7:0]   a_wmask;
    logic [15:0]  a_cnt;

    logic [7:0]   b_addr;
    logic         b_en, b_wmode, b_ready, b_rvalid;
    logic [127:0] b_wdata, b_rdata;
    logic [15:0]  b_wmask;
    logic [15:0]  b_cnt;

    mem_1rw_mask_rmw dut_a (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(a_addr), .RW0_en(a_en),
        .RW0_wmode(a_wmode), .RW0_wdata(a_wdata), .RW0_wmask(a_wmask),
        .RW0_ready(a_ready), .RW0_rdata(a_rdata), .RW0_rvalid(a_rvalid),
        .RW0_rmw_count(a_cnt)
    );

    mem_1rw_mask_rmw #(.DEPTH(200), .WIDTH(128)) dut_b (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(b_addr), .RW0_en(b_en),
        .RW0_wmode(b_wmode), .RW0_wdata(b_wdata), .RW0_wmask(b_wmask),
        .RW0_ready(b_ready), .RW0_rdata(b_rdata), .RW0_rvalid(b_rvalid),
        .RW0_rmw_count(b_cnt)
    );

    typedef struct {
        bit          wmode;
        int          addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        bit          exp_rvalid;
        logic [63:0] exp_rdata;
        bit          exp_stall;
        bit          exp_nocen;
        int          exp_cnt;
    } vec_t;

    vec_t vt[$];
    int   nvec = 0;
    int   nbad = 0;

    function automatic vec_t mk(bit wm, int ad, logic [63:0] wd, logic [7:0] wk, bit rv,
                                logic [63:0] rd, bit st, bit nc, int cnt);
        vec_t v;
        v.wmode = wm; v.addr = ad; v.wdata = wd; v.wmask = wk; v.exp_rvalid = rv;
        v.exp_rdata = rd; v.exp_stall = st; v.exp_nocen = nc; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // called at a negedge; returns one negedge (plus #1) after acceptance/completion
    task automatic apply_a(input vec_t v);
        a_en = 1'b1; a_wmode = v.wmode; a_addr = 6'(v.addr);
        a_wdata = v.wdata; a_wmask = v.wmask;
        #1;
        chk("a_ready_pre", 128'(a_ready), 128'(1));
        if (v.exp_nocen) chk("a_no_cen", 128'(&dut_a.cen), 128'(1));
        @(negedge clk);
        a_en = 1'b0;
        #1;
        chk("a_rvalid", 128'(a_rvalid), 128'(v.exp_rvalid));
        if (v.exp_rvalid) chk("a_rdata", 128'(a_rdata), 128'(v.exp_rdata));
        chk("a_ready_post", 128'(a_ready), 128'(!v.exp_stall));
        if (v.exp_stall) begin
            @(negedge clk);
            #1;
            chk("a_ready_back", 128'(a_ready), 128'(1));
        end
        chk("a_rmw_count", 128'(a_cnt), 128'(v.exp_cnt));
    endtask

    task automatic b_op(input bit wm, input int ad, input logic [127:0] wd,
                        input logic [15:0] wk, input logic [3:0] exp_cen);
        b_en = 1'b1; b_wmode = wm; b_addr = 8'(ad); b_wdata = wd; b_wmask = wk;
        #1;
        chk("b_ready_pre", 128'(b_ready), 128'(1));
        chk("b_cen", 128'(dut_b.cen), 128'(exp_cen));
        @(negedge clk);
        b_en = 1'b0;
        #1;
    endtask

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D2 = 128'hCAFE_F00D_1357_9BDF_2468_ACE0_5A5A_A5A5;

    initial begin
        rst = 1'b1;
        a_en = 1'b0; a_wmode = 1'b0; a_addr = '0; a_wdata = '0; a_wmask = '0;
        b_en = 1'b0; b_wmode = 1'b0; b_addr = '0; b_wdata = '0; b_wmask = '0;

        for (int i = 0; i < 4; i++)
            vt.push_back(mk(1, i, 64'h1111_0000_0000_0000 | 64'(i), 8'hFF, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(0, i, 0, 8'h00, 1, 64'h1111_0000_0000_0000 | 64'(i), 0, 0, 0));
        vt.push_back(mk(1, 5, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0, 1, 0, 1));
        vt.push_back(mk(0, 5, 0, 8'h00, 1, 64'h0123_4567_FFFF_FFFF, 0, 0, 1));
        vt.push_back(mk(1, 5, 64'h0, 8'h00, 0, 0, 0, 1, 1));
        vt.push_back(mk(0, 5, 0, 8'h00, 1, 64'h0123_4567_FFFF_FFFF, 0, 0, 1));
        vt.push_back(mk(0, 48, 0, 8'h00, 1, 64'h0, 0, 1, 1));
        vt.push_back(mk(1, 48, 64'h5555_5555_5555_5555, 8'hFF, 0, 0, 0, 1, 1));
        vt.push_back(mk(1, 48, 64'h5555_5555_5555_5555, 8'h0F, 0, 0, 0, 1, 1));
        vt.push_back(mk(1, 47, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 47, 0, 8'h00, 1, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 1));
        vt.push_back(mk(1, 47, 64'h0, 8'hF0, 0, 0, 1, 0, 2));
        vt.push_back(mk(0, 47, 0, 8'h00, 1, 64'h0000_0000_0BAD_F00D, 0, 0, 2));
        vt.push_back(mk(1, 10, 64'hAAAA_5555_AAAA_5555, 8'hFF, 0, 0, 0, 0, 2));

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready_low", 128'(a_ready), 128'(0));
        chk("rst_cen_all", 128'(&dut_a.cen), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 128'(a_ready), 128'(1));
        chk("rst_rvalid", 128'(a_rvalid), 128'(0));
        chk("rst_rdata", 128'(a_rdata), 128'(0));
        chk("rst_cnt", 128'(a_cnt), 128'(0));

        foreach (vt[i]) apply_a(vt[i]);

        // reset lands in the MERGE cycle: the write must be dropped
        a_en = 1'b1; a_wmode = 1'b1; a_addr = 6'd10; a_wdata = 64'h0; a_wmask = 8'h0F;
        #1;
        chk("abort_ready_pre", 128'(a_ready), 128'(1));
        @(negedge clk);
        a_en = 1'b0; rst = 1'b1;
        #1;
        chk("abort_cen_all", 128'(&dut_a.cen), 128'(1));
        chk("abort_ready_low", 128'(a_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", 128'(a_ready), 128'(1));
        chk("abort_cnt", 128'(a_cnt), 128'(0));
        chk("abort_rdata", 128'(a_rdata), 128'(0));
        chk("abort_rvalid", 128'(a_rvalid), 128'(0));
        apply_a(mk(0, 10, 0, 8'h00, 1, 64'hAAAA_5555_AAAA_5555, 0, 0, 0));

        // second configuration: two banks, two columns
        b_op(1, 130, D1, 16'hFFFF, 4'b0011);
        b_op(1, 2, D2, 16'hFFFF, 4'b1100);
        b_op(0, 130, 0, 16'h0, 4'b0011);
        chk("b_rvalid_130", 128'(b_rvalid), 128'(1));
        chk("b_rdata_130", b_rdata, D1);
        b_op(0, 2, 0, 16'h0, 4'b1100);
        chk("b_rvalid_2", 128'(b_rvalid), 128'(1));
        chk("b_rdata_2", b_rdata, D2);
        b_op(1, 130, {128{1'b1}}, 16'h00F0, 4'b0011);
        chk("b_rmw_stall", 128'(b_ready), 128'(0));
        chk("b_rmw_norvalid", 128'(b_rvalid), 128'(0));
        @(negedge clk);
        #1;
        chk("b_rmw_ready", 128'(b_ready), 128'(1));
        chk("b_rmw_cnt", 128'(b_cnt), 128'(1));
        b_op(0, 130, 0, 16'h0, 4'b0011);
        chk("b_merged", b_rdata, 128'h0123_4567_89AB_CDEF_FFFF_FFFF_7654_3210);
        b_op(0, 2, 0, 16'h0, 4'b1100);
        chk("b_rdata_2_after", b_rdata, D2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
